// File: rtl/shared_datapath_arbiter.sv
// Two-requester round-robin arbiter feeding a shared pass/increment datapath.
// The result is held in a one-entry output register tagged with the winning
// requester index. A free-running counter tracks delivered results.
module shared_datapath_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 io_in_0_valid,
    output logic                 io_in_0_ready,
    input  logic [WIDTH-1:0]     io_in_0_bits_a,
    input  logic                 io_in_0_bits_op,

    input  logic                 io_in_1_valid,
    output logic                 io_in_1_ready,
    input  logic [WIDTH-1:0]     io_in_1_bits_a,
    input  logic                 io_in_1_bits_op,

    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [WIDTH-1:0]     io_out_bits_b,
    output logic                 io_out_bits_id,

    output logic [CNT_WIDTH-1:0] io_count
);

    localparam logic [WIDTH-1:0]     DataOne = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Result register and arbitration state
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_b_q, out_b_d;
    logic                 out_id_q, out_id_d;
    logic                 last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Combinational arbitration and datapath signals
    logic             can_accept;
    logic             grant_vld;
    logic             grant_idx;
    logic             accept;
    logic             out_fire;
    logic [WIDTH-1:0] sel_a;
    logic             sel_op;
    logic [WIDTH-1:0] result;

    // Round-robin grant: on contention the requester that did not win last goes next.
    always_comb begin
        grant_vld = io_in_0_valid | io_in_1_valid;
        grant_idx = 1'b0;
        if (io_in_0_valid && io_in_1_valid) begin
            grant_idx = ~last_grant_q;
        end else if (io_in_1_valid) begin
            grant_idx = 1'b1;
        end
    end

    // Handshake: the register can load when empty or being drained this cycle.
    always_comb begin
        can_accept    = !out_valid_q || io_out_ready;
        io_in_0_ready = can_accept && grant_vld && !grant_idx;
        io_in_1_ready = can_accept && grant_vld && grant_idx;
        // A ready is only raised for a valid requester, so either ready is an accept.
        accept        = io_in_0_ready || io_in_1_ready;
        out_fire      = out_valid_q && io_out_ready;
    end

    // Shared datapath: pass-through or increment (wraps at WIDTH bits).
    always_comb begin
        sel_a  = grant_idx ? io_in_1_bits_a : io_in_0_bits_a;
        sel_op = grant_idx ? io_in_1_bits_op : io_in_0_bits_op;
        result = sel_op ? (sel_a + DataOne) : sel_a;
    end

    // Next-state: reload on accept (even while draining), clear on a bare drain.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_b_d      = out_b_q;
        out_id_d     = out_id_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;

        if (accept) begin
            out_valid_d  = 1'b1;
            out_b_d      = result;
            out_id_d     = grant_idx;
            // Priority rotates only on a real accept, never on a stalled grant.
            last_grant_d = grant_idx;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (out_fire) begin
            count_d = count_q + CntOne;
        end
    end

    // State registers; last_grant resets to 1 so requester 0 wins first contention.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_b_q      <= '0;
            out_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            count_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_b_q      <= out_b_d;
            out_id_q     <= out_id_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

    // Output drive straight from the registers.
    always_comb begin
        io_out_valid   = out_valid_q;
        io_out_bits_b  = out_b_q;
        io_out_bits_id = out_id_q;
        io_count       = count_q;
    end

endmodule

// File: tb/tb_shared_datapath_arbiter.sv
// Self-checking bench for shared_datapath_arbiter against a transaction-level model.
module tb_shared_datapath_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        in0_valid, in0_ready, in0_op;
    logic [31:0] in0_a;
    logic        in1_valid, in1_ready, in1_op;
    logic [31:0] in1_a;
    logic        out_valid, out_ready, out_id;
    logic [31:0] out_b;
    logic [15:0] count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_b;
    bit          m_id;
    bit          m_last;
    int unsigned m_cnt;

    always #5 clock = ~clock;

    shared_datapath_arbiter #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_in_0_valid   (in0_valid),
        .io_in_0_ready   (in0_ready),
        .io_in_0_bits_a  (in0_a),
        .io_in_0_bits_op (in0_op),
        .io_in_1_valid   (in1_valid),
        .io_in_1_ready   (in1_ready),
        .io_in_1_bits_a  (in1_a),
        .io_in_1_bits_op (in1_op),
        .io_out_valid    (out_valid),
        .io_out_ready    (out_ready),
        .io_out_bits_b   (out_b),
        .io_out_bits_id  (out_id),
        .io_count        (count)
    );

    function automatic void model_reset();
        m_valid = 0;
        m_b     = 32'h0;
        m_id    = 0;
        m_last  = 1;
        m_cnt   = 0;
    endfunction

    // Which requester should win now: -1 none, else index.
    function automatic int exp_grant();
        if (in0_valid && in1_valid) return (m_last == 1) ? 0 : 1;
        if (in0_valid) return 0;
        if (in1_valid) return 1;
        return -1;
    endfunction

    function automatic bit exp_ready(int k);
        return (!m_valid || out_ready) && (exp_grant() == k);
    endfunction

    // Advance one clock and update the model from the inputs seen before the edge.
    task automatic step();
        int          g;
        bit          can;
        logic [31:0] a;
        bit          op;
        g   = exp_grant();
        can = !m_valid || out_ready;
        a   = (g == 1) ? in1_a : in0_a;
        op  = (g == 1) ? in1_op : in0_op;
        @(posedge clock);
        if (m_valid && out_ready) m_cnt = (m_cnt + 1) % 65536;
        if (can && g >= 0) begin
            m_valid = 1;
            m_b     = op ? a + 32'd1 : a;
            m_id    = (g == 1);
            m_last  = (g == 1);
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in0_valid = 0; in0_a = 0; in0_op = 0;
        in1_valid = 0; in1_a = 0; in1_op = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        out_ready = 1;
        model_reset();
        #3;
        total++;
        if (out_valid !== 1'b0 || count !== 16'h0 || out_b !== 32'h0 || out_id !== 1'b0) begin
            bad++;
            $display("FAIL reset_values got v=%b cnt=%0d b=%h id=%b exp v=0 cnt=0 b=0 id=0",
                     out_valid, count, out_b, out_id);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b0 || in0_ready !== 1'b0 || in1_ready !== 1'b0 || count !== 16'h0)
            begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got v=%b r0=%b r1=%b cnt=%0d exp 0 0 0 0",
                         i, out_valid, in0_ready, in1_ready, count);
            end
            step();
        end
    endtask

    task automatic test_single();
        in0_valid = 1; in0_a = 32'h10; in0_op = 0;
        out_ready = 1;
        #1;
        total++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_ready got r0=%b r1=%b exp r0=1 r1=0", in0_ready, in1_ready);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_b !== 32'h10 || out_id !== 1'b0 || count !== 16'd0) begin
            bad++;
            $display("FAIL single_result got v=%b b=%h id=%b cnt=%0d exp v=1 b=00000010 id=0 cnt=0",
                     out_valid, out_b, out_id, count);
        end
        step();
        #1;
        total++;
        if (count !== 16'd1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_count got cnt=%0d v=%b exp cnt=1 v=0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned start_cnt;
        int          delivered;
        int          prev_id;
        start_cnt = m_cnt;
        delivered = 0;
        prev_id   = -1;
        out_ready = 1;
        for (int cyc = 0; cyc < 20 && delivered < 8; cyc++) begin
            in0_valid = 1; in0_a = $urandom; in0_op = 1'($urandom_range(0, 1));
            in1_valid = 1; in1_a = in0_a ^ 32'h5555_0000; in1_op = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (in0_ready !== exp_ready(0) || in1_ready !== exp_ready(1)) begin
                bad++;
                $display("FAIL b2b_ready cyc=%0d got r0=%b r1=%b exp r0=%b r1=%b",
                         cyc, in0_ready, in1_ready, exp_ready(0), exp_ready(1));
            end
            if (m_valid) begin
                total++;
                if (out_valid !== 1'b1 || out_b !== m_b || out_id !== m_id ||
                    (prev_id >= 0 && int'(out_id) == prev_id)) begin
                    bad++;
                    $display("FAIL b2b_out cyc=%0d got v=%b b=%h id=%b exp v=1 b=%h id=%b prev=%0d",
                             cyc, out_valid, out_b, out_id, m_b, m_id, prev_id);
                end
                prev_id = int'(m_id);
                delivered++;
            end
            step();
        end
        idle_inputs();
        #1;
        total++;
        if (count !== 16'((start_cnt + 8) % 65536) || delivered != 8) begin
            bad++;
            $display("FAIL b2b_count got cnt=%0d delivered=%0d exp cnt=%0d delivered=8",
                     count, delivered, (start_cnt + 8) % 65536);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] held_b;
        bit          held_id;
        // Load one result from requester 0.
        in0_valid = 1; in0_a = 32'hCAFE_0001; in0_op = 1; out_ready = 1;
        #1;
        step();
        idle_inputs();
        out_ready = 0;
        held_b  = 32'hCAFE_0002;
        held_id = 0;
        in1_valid = 1; in1_a = 32'h1234_5678; in1_op = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_b !== held_b || out_id !== held_id) begin
                bad++;
                $display("FAIL stall cyc=%0d got r0=%b r1=%b v=%b b=%h id=%b exp 0 0 1 %h %b",
                         i, in0_ready, in1_ready, out_valid, out_b, out_id, held_b, held_id);
            end
            step();
        end
        out_ready = 1;
        #1;
        total++;
        if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_release got r0=%b r1=%b exp r0=0 r1=1", in0_ready, in1_ready);
        end
        step();
        in1_valid = 0;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_id !== 1'b1 || out_b !== 32'h1234_5678) begin
            bad++;
            $display("FAIL stall_reload got v=%b id=%b b=%h exp v=1 id=1 b=12345678",
                     out_valid, out_id, out_b);
        end
        step();
    endtask

    task automatic test_increment();
        logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h0000_0007, 32'hDEAD_BEEF};
        bit          top [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] tb [3] = '{32'h0000_0000, 32'h0000_0008, 32'hDEAD_BEEF};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in0_valid = 1; in0_a = ta[i]; in0_op = top[i];
            #1;
            step();
            idle_inputs();
            #1;
            total++;
            if (out_valid !== 1'b1 || out_b !== tb[i] || out_id !== 1'b0) begin
                bad++;
                $display("FAIL incr case=%0d got v=%b b=%h id=%b exp v=1 b=%h id=0",
                         i, out_valid, out_b, out_id, tb[i]);
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in0_valid = ($urandom_range(0, 3) != 0);
            in1_valid = ($urandom_range(0, 3) != 0);
            in0_a     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            in1_a     = $urandom;
            in0_op    = 1'($urandom_range(0, 1));
            in1_op    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (in0_ready !== exp_ready(0) || in1_ready !== exp_ready(1) ||
                out_valid !== m_valid || count !== 16'(m_cnt) ||
                (m_valid && (out_b !== m_b || out_id !== m_id))) begin
                bad++;
                $display("FAIL random cyc=%0d got r0=%b r1=%b v=%b b=%h id=%b cnt=%0d exp %b %b %b %h %b %0d",
                         cyc, in0_ready, in1_ready, out_valid, out_b, out_id, count,
                         exp_ready(0), exp_ready(1), m_valid, m_b, m_id, m_cnt);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        // Clean start, then three deliveries plus one pending result.
        reset = 0;
        #2;
        reset = 1;
        model_reset();
        idle_inputs();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in0_valid = 1; in0_a = 32'(i + 100); in0_op = 0;
            #1;
            step();
        end
        idle_inputs();
        out_ready = 0;
        #2;
        total++;
        if (out_valid !== 1'b1 || count !== 16'd3) begin
            bad++;
            $display("FAIL areset_pre got v=%b cnt=%0d exp v=1 cnt=3", out_valid, count);
        end
        reset = 0;
        model_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || count !== 16'd0 || out_b !== 32'h0 || out_id !== 1'b0) begin
            bad++;
            $display("FAIL areset_now got v=%b cnt=%0d b=%h id=%b exp v=0 cnt=0 b=0 id=0",
                     out_valid, count, out_b, out_id);
        end
        #1;
        reset = 1;
        out_ready = 1;
        in0_valid = 1; in0_a = 32'hA0; in0_op = 0;
        in1_valid = 1; in1_a = 32'hB0; in1_op = 0;
        #1;
        total++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            bad++;
            $display("FAIL areset_first_grant got r0=%b r1=%b exp r0=1 r1=0",
                     in0_ready, in1_ready);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_id !== 1'b0 || out_b !== 32'hA0) begin
            bad++;
            $display("FAIL areset_first_result got v=%b id=%b b=%h exp v=1 id=0 b=000000a0",
                     out_valid, out_id, out_b);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_increment();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
